// File: rtl/pkt_phase_tagger_if.sv
// rtl/pkt_phase_tagger_if.sv - packet stream in / tagged text word out bundle for pkt_phase_tagger
//
// Purpose: groups the upstream packet handshake and the downstream tagged-word
// outputs of pkt_phase_tagger so they travel as one port.
//
// Signals:
//   s_valid     upstream word valid
//   s_ready     tagger can accept a word this cycle
//   s_data      256-bit payload word
//   s_meta      32-bit per-word sideband, passed through
//   s_sop/s_eop first / last word of packet markers
//   o_text      {eop, meta, data} of the emitted word (289 bits)
//   o_state     one-hot phase: 0 idle, 1 FIRST, 2 SECOND, 4 INNER
//   o_last      emitted word is last of packet
//   o_ready     one-cycle strobe qualifying o_text/o_state/o_last
//   o_pkt_cnt   completed packet count (wraps)
//   o_proto_err sticky protocol error
//
// Modports: master = packet source / text sink, slave = the tagger.

interface pkt_phase_tagger_if;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_data;
  logic [31:0]  s_meta;
  logic         s_sop;
  logic         s_eop;
  logic [288:0] o_text;
  logic [0:3]   o_state;
  logic         o_last;
  logic         o_ready;
  logic [15:0]  o_pkt_cnt;
  logic         o_proto_err;

  modport master (
    output s_valid, s_data, s_meta, s_sop, s_eop,
    input  s_ready, o_text, o_state, o_last, o_ready, o_pkt_cnt, o_proto_err
  );

  modport slave (
    input  s_valid, s_data, s_meta, s_sop, s_eop,
    output s_ready, o_text, o_state, o_last, o_ready, o_pkt_cnt, o_proto_err
  );
endinterface

// File: rtl/pkt_phase_tagger.sv
// rtl/pkt_phase_tagger.sv - packet framing stage tagging words with GCM phase and inserting flush gaps
//
// Purpose: accepts a stream of 256-bit packet words and emits each one, one
// cycle later, as a 289-bit text word tagged with its phase within the packet
// (FIRST, SECOND, INNER), a last flag and a one-cycle ready strobe. After the
// last word of a packet, GAP idle cycles are forced (phase held at FIRST,
// s_ready low) so the downstream phase-alignment stage can drain.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pkt_phase_tagger_if.slave (see interface file for signal list)
//
// Parameters:
//   GAP  number of flush cycles after each packet's last word (>= 0)

module pkt_phase_tagger #(
  parameter int GAP = 2
) (
  input  logic                clk,
  input  logic                rst,
  pkt_phase_tagger_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SECOND,
    ST_INNER,
    ST_GAP
  } state_e;

  localparam int                CNT_W    = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP);

  localparam logic [0:3] PH_IDLE   = 4'd0;
  localparam logic [0:3] PH_FIRST  = 4'd1;
  localparam logic [0:3] PH_SECOND = 4'd2;
  localparam logic [0:3] PH_INNER  = 4'd4;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic [288:0]       text_q,      text_d;
  logic [0:3]         phase_q,     phase_d;
  logic               last_q,      last_d;
  logic               ready_q,     ready_d;
  logic [15:0]        pkt_cnt_q,   pkt_cnt_d;
  logic               proto_err_q, proto_err_d;

  logic               s_ready_int;
  logic               accept;
  logic               emit;
  logic [0:3]         emit_phase;
  state_e             emit_state;

  // The word-accept window is a pure function of the state register; reset
  // forces it low so nothing is taken while the block is held.
  assign s_ready_int = (state_q != ST_GAP) && !rst;
  assign accept      = bus.s_valid && s_ready_int;

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    text_d      = text_q;
    phase_d     = phase_q;
    last_d      = 1'b0;
    ready_d     = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    proto_err_d = proto_err_q;
    emit        = 1'b0;
    emit_phase  = PH_FIRST;
    emit_state  = ST_FIRST;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.s_sop) begin
            emit       = 1'b1;
            emit_phase = PH_FIRST;
            emit_state = ST_FIRST;
          end else begin
            // Orphan word with no packet open: dropped.
            proto_err_d = 1'b1;
          end
        end
      end

      ST_FIRST, ST_SECOND, ST_INNER: begin
        if (accept) begin
          emit = 1'b1;
          if (bus.s_sop) begin
            // Restart: the open packet is abandoned without an o_last and
            // this word becomes the FIRST word of a fresh packet.
            proto_err_d = 1'b1;
            emit_phase  = PH_FIRST;
            emit_state  = ST_FIRST;
          end else if (state_q == ST_FIRST) begin
            emit_phase = PH_SECOND;
            emit_state = ST_SECOND;
          end else begin
            emit_phase = PH_INNER;
            emit_state = ST_INNER;
          end
        end else if (!bus.s_valid) begin
          // Mid-packet bubble: flagged, FSM and phase output hold.
          proto_err_d = 1'b1;
        end
      end

      ST_GAP: begin
        // The counter is loaded with GAP in the emission cycle of the last
        // word, so the FSM spends GAP+1 cycles here: the emission cycle
        // itself plus GAP flush cycles showing phase FIRST.
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
          phase_d = PH_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
          phase_d   = PH_FIRST;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
    endcase

    if (emit) begin
      text_d  = {bus.s_eop, bus.s_meta, bus.s_data};
      phase_d = emit_phase;
      ready_d = 1'b1;
      if (bus.s_eop) begin
        last_d    = 1'b1;
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LOAD;
      end else begin
        state_d = emit_state;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      text_q      <= '0;
      phase_q     <= PH_IDLE;
      last_q      <= 1'b0;
      ready_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      text_q      <= text_d;
      phase_q     <= phase_d;
      last_q      <= last_d;
      ready_q     <= ready_d;
      pkt_cnt_q   <= pkt_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.s_ready     = s_ready_int;
  assign bus.o_text      = text_q;
  assign bus.o_state     = phase_q;
  assign bus.o_last      = last_q;
  assign bus.o_ready     = ready_q;
  assign bus.o_pkt_cnt   = pkt_cnt_q;
  assign bus.o_proto_err = proto_err_q;

endmodule

// File: tb/tb_pkt_phase_tagger.sv
// tb/tb_pkt_phase_tagger.sv - self-checking bench for pkt_phase_tagger

module tb_pkt_phase_tagger;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pkt_phase_tagger_if bus();

  pkt_phase_tagger #(.GAP(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [288:0] got, input logic [288:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: tracks the packet position, the edge index of the last
  // accepted eop and the resulting readiness window with plain arithmetic.
  int           e;
  bit           m_in_pkt;
  int           m_pos;
  int           m_last_eop;
  logic [288:0] m_text;
  logic [3:0]   m_state;
  logic         m_last;
  logic         m_oready;
  logic [15:0]  m_cnt;
  logic         m_err;

  function automatic void model_reset();
    e          = 0;
    m_in_pkt   = 1'b0;
    m_pos      = 0;
    m_last_eop = -100;
    m_text     = '0;
    m_state    = 4'd0;
    m_last     = 1'b0;
    m_oready   = 1'b0;
    m_cnt      = 16'd0;
    m_err      = 1'b0;
  endfunction

  task automatic drive(input bit v, input bit sop, input bit eop,
                       input logic [255:0] d, input logic [31:0] m);
    bus.s_valid = v;
    bus.s_sop   = sop;
    bus.s_eop   = eop;
    bus.s_data  = d;
    bus.s_meta  = m;
  endtask

  // Entered and left just after a falling edge; one clock per call.
  task automatic step(input bit v, input bit sop, input bit eop,
                      input logic [255:0] d, input logic [31:0] m);
    bit rdy;
    bit acc;
    drive(v, sop, eop, d, m);
    rdy = (e >= m_last_eop + GAP + 2);
    #1;
    chk("s_ready", 289'(bus.s_ready), 289'(rdy));
    @(posedge clk);
    #1;
    acc      = v && rdy;
    m_oready = 1'b0;
    m_last   = 1'b0;
    if (acc && !m_in_pkt && !sop) begin
      m_err = 1'b1;
    end else if (acc) begin
      if (m_in_pkt && sop) m_err = 1'b1;
      m_pos    = sop ? 0 : m_pos + 1;
      m_state  = (m_pos == 0) ? 4'd1 : (m_pos == 1) ? 4'd2 : 4'd4;
      m_text   = {eop, m, d};
      m_oready = 1'b1;
      m_last   = eop;
      if (eop) begin
        m_cnt      = m_cnt + 16'd1;
        m_in_pkt   = 1'b0;
        m_last_eop = e;
      end else begin
        m_in_pkt = 1'b1;
      end
    end else if (m_in_pkt) begin
      if (!v) m_err = 1'b1;
    end else begin
      m_state = (e <= m_last_eop + GAP) ? 4'd1 : 4'd0;
    end
    e++;
    chk("o_ready",     289'(bus.o_ready),     289'(m_oready));
    chk("o_state",     289'(bus.o_state),     289'(m_state));
    chk("o_last",      289'(bus.o_last),      289'(m_last));
    chk("o_text",      bus.o_text,            m_text);
    chk("o_pkt_cnt",   289'(bus.o_pkt_cnt),   289'(m_cnt));
    chk("o_proto_err", 289'(bus.o_proto_err), 289'(m_err));
    @(negedge clk);
  endtask

  // Holds rst for three cycles checking that every output is cleared.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_s_ready",     289'(bus.s_ready),     289'(0));
      chk("rst_o_text",      bus.o_text,            289'(0));
      chk("rst_o_state",     289'(bus.o_state),     289'(0));
      chk("rst_o_last",      289'(bus.o_last),      289'(0));
      chk("rst_o_ready",     289'(bus.o_ready),     289'(0));
      chk("rst_o_pkt_cnt",   289'(bus.o_pkt_cnt),   289'(0));
      chk("rst_o_proto_err", 289'(bus.o_proto_err), 289'(0));
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          v;
    bit          sop;
    bit          eop;
    logic [7:0]  db;
    logic [31:0] meta;
    bit          x_sr;
    bit          x_or;
    logic [3:0]  x_st;
    bit          x_last;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t         tbl [12];
  logic [288:0] exp_text;
  logic [255:0] rd;

  initial begin
    // 4-word packet, then a single-word packet offered during the flush gap
    // (accepted GAP+2 edges after the eop), then idle cycles.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h11, 32'h0000_0011, 1'b1, 1'b1, 4'd1, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 32'h0000_0022, 1'b1, 1'b1, 4'd2, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 32'h0000_0033, 1'b1, 1'b1, 4'd4, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h44, 32'h0000_0044, 1'b1, 1'b1, 4'd4, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 32'h0000_1234, 1'b0, 1'b0, 4'd1, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 32'h0000_1234, 1'b0, 1'b0, 4'd1, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 32'h0000_1234, 1'b0, 1'b0, 4'd0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 32'h0000_1234, 1'b1, 1'b1, 4'd1, 1'b1, 16'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd2};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    do_reset();

    exp_text = '0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, {32{tbl[i].db}}, tbl[i].meta);
      #1;
      chk($sformatf("tbl%0d_s_ready", i), 289'(bus.s_ready), 289'(tbl[i].x_sr));
      @(posedge clk);
      #1;
      if (tbl[i].x_or) exp_text = {tbl[i].eop, tbl[i].meta, {32{tbl[i].db}}};
      chk($sformatf("tbl%0d_o_ready", i),     289'(bus.o_ready),     289'(tbl[i].x_or));
      chk($sformatf("tbl%0d_o_state", i),     289'(bus.o_state),     289'(tbl[i].x_st));
      chk($sformatf("tbl%0d_o_last", i),      289'(bus.o_last),      289'(tbl[i].x_last));
      chk($sformatf("tbl%0d_o_text", i),      bus.o_text,            exp_text);
      chk($sformatf("tbl%0d_o_pkt_cnt", i),   289'(bus.o_pkt_cnt),   289'(tbl[i].x_cnt));
      chk($sformatf("tbl%0d_o_proto_err", i), 289'(bus.o_proto_err), 289'(0));
      @(negedge clk);
    end

    // Orphan word in IDLE, then a restart mid-packet.
    do_reset();
    step(1'b1, 1'b0, 1'b0, {8{32'h0BAD_0001}}, 32'h1);
    step(1'b1, 1'b1, 1'b0, {8{32'h1111_0001}}, 32'h2);
    step(1'b1, 1'b0, 1'b0, {8{32'h1111_0002}}, 32'h3);
    step(1'b1, 1'b1, 1'b0, {8{32'h2222_0001}}, 32'h4);
    chk("restart_state", 289'(bus.o_state), 289'(1));
    step(1'b1, 1'b0, 1'b0, {8{32'h2222_0002}}, 32'h5);
    chk("restart_state2", 289'(bus.o_state), 289'(2));
    step(1'b1, 1'b0, 1'b1, {8{32'h2222_0003}}, 32'h6);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
    chk("proto_err_sticky", 289'(bus.o_proto_err), 289'(1));
    chk("restart_cnt", 289'(bus.o_pkt_cnt), 289'(1));

    // Reset in the INNER phase, then a fresh packet.
    do_reset();
    step(1'b1, 1'b1, 1'b0, {8{32'hCAFE_0001}}, 32'h10);
    step(1'b1, 1'b0, 1'b0, {8{32'hCAFE_0002}}, 32'h11);
    step(1'b1, 1'b0, 1'b0, {8{32'hCAFE_0003}}, 32'h12);
    do_reset();
    step(1'b1, 1'b1, 1'b0, {8{32'hBEEF_0001}}, 32'h20);
    chk("post_rst_state", 289'(bus.o_state), 289'(1));
    step(1'b1, 1'b0, 1'b1, {8{32'hBEEF_0002}}, 32'h21);
    chk("post_rst_cnt", 289'(bus.o_pkt_cnt), 289'(1));
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit v;
      bit sop;
      bit eop;
      rd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      v   = ($urandom % 10) != 0;
      sop = m_in_pkt ? (($urandom % 20) == 0) : (($urandom % 8) != 0);
      eop = ($urandom % 4) == 0;
      step(v, sop, eop, rd, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
